inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front end between the pipeline's decode stage and the instruction cache. Generates the sequential fetch PC and drives the cache address/enable pins, honouring the cache's active-low stall. Buffers returned instructions with their PCs in a small queue for decode. Handles branch/jump redirects by flushing queued and in-flight instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `FQ_DEPTH`, 4: fetch-queue entries (power of two, 2..16).
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ic_req` out 1: cache enable, active-high; wired to the cache chip-enable pin.
- `ic_addr` out 32: fetch address to cache.
- `ic_data` in 32: cache data out.
- `ic_stall_n` in 1: cache stall, 0 = miss refill in progress.
- `redirect_valid` in 1: one-cycle branch/jump redirect strobe.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (forced 00).
- `dec_valid` out 1: queue head valid.
- `dec_inst` out 32: queue head instruction.
- `dec_pc` out 32: queue head PC.
- `dec_ready` in 1: decode accepts head.

## Operation
- Registers:
  - `fetch_pc` (next address to issue).
  - `pend_pc`.
  - Request FSM: IDLE (nothing in flight), PEND (one request in flight), PEND_SQ (in flight, result to be discarded).
- Address mux: `ic_addr = (state!=IDLE && !ic_stall_n) ? pend_pc : fetch_pc`. This holds the missing address stable for the whole refill.
- `can_issue = ic_stall_n && (count + (state!=IDLE)) < FQ_DEPTH`, using current-cycle count; pops in the same cycle earn no credit.
- `ic_req = can_issue || state!=IDLE`. It must stay 1 throughout a stall; dropping enable during a miss corrupts the cache FSM.
- Issue at an edge with `can_issue`:
  - `pend_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^32).
  - Go to PEND.
- Response:
  - A request completes in the first cycle after issue with `ic_stall_n=1`.
  - At that edge, PEND pushes {`ic_data`, `pend_pc`} into the queue and PEND_SQ discards the data.
  - The next state is PEND if a new issue occurs in the same cycle, else IDLE. Back-to-back hits sustain one fetch per cycle.
- Redirect at an edge:
  - Queue flushed (count <= 0).
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - An in-flight request that does not complete at that edge goes to PEND_SQ.
  - A request completing at the same edge is discarded, not pushed.
  - No issue occurs at the redirect edge, so the target is issued no earlier than the following cycle.
  - A redirect during a stall leaves `ic_addr` at `pend_pc` until `ic_stall_n` returns to 1.
- Queue:
  - FWFT; `dec_*` show the head combinationally from storage; no capture-to-output bypass.
  - Pop on `dec_valid && dec_ready`; a redirect overrides a simultaneous pop.
  - Push and pop in the same cycle are legal. Overflow is impossible by the issue rule.

## Timing
- Reset values:
  - Outputs: `ic_req`=0, `ic_addr`=`RESET_PC`, `dec_valid`=0, `dec_inst`=0, `dec_pc`=0.
  - Registers: FSM IDLE, count 0, perf counters 0.
- Reset asserted mid-operation aborts any in-flight request with no push. Reset wins over redirect.
- Cycle 0 is the first cycle with `rst_n`=1: `ic_req`=1, `ic_addr`=`RESET_PC`.
- Hit: data captured at the end of cycle 1; `dec_valid`=1 in cycle 2.
- Miss (cache stalls 2 cycles): capture at the end of cycle 3; `dec_valid` in cycle 4.
- Redirect at end of cycle r (no in-flight request): target issued in cycle r+1, `dec_valid` for target in cycle r+3.

## Configuration
- `IFU_PERF_EN` defined adds two ports:
  - `perf_fetch_cnt` out 32: +1 per pushed (non-discarded) instruction.
  - `perf_stall_cnt` out 32: +1 per cycle with state!=IDLE and `ic_stall_n`=0.
  - Both wrap modulo 2^32 and reset to 0.
- `IFU_PERF_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `ifu_pkg`: FSM state encoding (IDLE/PEND/PEND_SQ), instruction/address width constants, queue entry struct {inst, pc}.
- Sub-module `fetch_queue`: parameterised FWFT FIFO with push, pop, flush, count. Flush has priority over push and pop.

## Test plan
- All-hit cache model (`ic_data = pc ^ 32'hA5A5_0000`), `dec_ready`=1 → `dec_pc` 0,4,8,… one per cycle from cycle 2, with matching `dec_inst`.
- Miss at 0x10 (stall_n=0 for 2 cycles) → `ic_addr`=0x10 and `ic_req`=1 both stall cycles; 0x10 is delivered once, in order, with no duplicate.
- `dec_ready`=0 for 10 cycles, `FQ_DEPTH`=4 → count saturates at 4 and `ic_req`=0; after release PCs continue contiguously with no loss.
- Redirect to 0x200 with 2 entries queued and a hit in flight → next `dec_pc`=0x200; no stale PC ever shown.
- Redirect to 0x300 during a miss stall at 0x40 → `ic_addr` stays 0x40 until stall_n=1, then 0x300 is issued; the 0x40 word is never presented; `perf_stall_cnt` +2 with `IFU_PERF_EN`.
- `rst_n`=0 for one cycle mid-stream → next cycle all outputs at reset values; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned InstW = 32;
    localparam int unsigned AddrW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StPendSq
    } fetch_state_e;

    typedef struct packed {
        logic [InstW-1:0] inst;
        logic [AddrW-1:0] pc;
    } fq_entry_t;

    function automatic logic [AddrW-1:0] align_pc(input logic [AddrW-1:0] pc);
        return pc & ~AddrW'(3);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Cache-side and decode-side signals of the fetch unit; master = fetch unit side.
interface ifu_if;
    import ifu_pkg::*;

    logic             ic_req;
    logic [AddrW-1:0] ic_addr;
    logic [InstW-1:0] ic_data;
    logic             ic_stall_n;
    logic             redirect_valid;
    logic [AddrW-1:0] redirect_pc;
    logic             dec_valid;
    logic [InstW-1:0] dec_inst;
    logic [AddrW-1:0] dec_pc;
    logic             dec_ready;

    modport master (
        output ic_req, ic_addr, dec_valid, dec_inst, dec_pc,
        input  ic_data, ic_stall_n, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  ic_req, ic_addr, dec_valid, dec_inst, dec_pc,
        output ic_data, ic_stall_n, redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through queue of {inst, pc}; flush beats push and pop.
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fq_entry_t                    entry_i,
    input  logic                         pop_i,
    output fq_entry_t                    head_o,
    output logic                         valid_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    fq_entry_t       mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_d = count_q + CntW'(1);
            else if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: sequential PC generation, I-cache handshake, redirect squash, fetch queue.
// Optional perf counters when IFU_PERF_EN is defined.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [AddrW-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned      FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_if.master       bus_io
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    localparam int unsigned     CntW     = $clog2(FQ_DEPTH + 1);
    localparam logic [CntW:0]   FqDepthW = (CntW + 1)'(FQ_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [AddrW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AddrW-1:0] pend_pc_q, pend_pc_d;
    logic [CntW-1:0]  fq_count;
    logic [CntW:0]    occupancy;
    logic             busy, can_issue, issue, push, pop;
    fq_entry_t        push_entry, head;

    always_comb begin
        busy      = (state_q != StIdle);
        // An in-flight request reserves a slot; same-cycle pops earn no credit.
        occupancy = {1'b0, fq_count} + {{CntW{1'b0}}, busy};
        can_issue = bus_io.ic_stall_n && (occupancy < FqDepthW);
        issue     = can_issue && !bus_io.redirect_valid;
        push      = (state_q == StPend) && bus_io.ic_stall_n && !bus_io.redirect_valid;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        if (bus_io.redirect_valid) begin
            fetch_pc_d = align_pc(bus_io.redirect_pc);
            state_d    = (busy && !bus_io.ic_stall_n) ? StPendSq : StIdle;
        end else if (issue) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + AddrW'(4);
            state_d    = StPend;
        end else if (busy && bus_io.ic_stall_n) begin
            state_d    = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // Enable must stay high through a refill; the address is held on pend_pc meanwhile.
    assign bus_io.ic_req  = rst_n && (can_issue || busy);
    assign bus_io.ic_addr = (busy && !bus_io.ic_stall_n) ? pend_pc_q : fetch_pc_q;

    assign push_entry.inst = bus_io.ic_data;
    assign push_entry.pc   = pend_pc_q;
    assign pop             = bus_io.dec_valid && bus_io.dec_ready;

    fetch_queue #(
        .Depth (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus_io.redirect_valid),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .valid_o (bus_io.dec_valid),
        .count_o (fq_count)
    );

    assign bus_io.dec_inst = head.inst;
    assign bus_io.dec_pc   = head.pc;

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (busy && !bus_io.ic_stall_n) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed table-driven bench for inst_fetch_unit with a one-cycle-latency cache model.
module tb_inst_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        logic        sn;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic        chk_perf;
        logic [31:0] e_fcnt;
        logic [31:0] e_scnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    ifu_if bus ();

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    inst_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus_io           (bus)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sn, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_dv, input logic [31:0] e_pc);
        vec_t v;
        v.sn = sn; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv; v.e_pc = e_pc;
        v.chk_perf = 1'b0; v.e_fcnt = '0; v.e_scnt = '0;
        return v;
    endfunction

    function automatic vec_t perf(input vec_t v, input logic [31:0] f, input logic [31:0] s);
        vec_t r;
        r = v;
        r.chk_perf = 1'b1; r.e_fcnt = f; r.e_scnt = s;
        return r;
    endfunction

    // Applies one cycle of inputs, checks outputs mid-cycle, and models the cache:
    // data for the address presented in a cycle appears in the next cycle.
    task automatic step(input vec_t v, input string tag);
        logic [31:0] a;
        logic        r;
        bus.ic_stall_n     = v.sn;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        bus.dec_ready      = v.rdy;
        @(negedge clk);
        check(tag, "ic_req",    {31'd0, bus.ic_req},    {31'd0, v.e_req});
        check(tag, "ic_addr",   bus.ic_addr,            v.e_addr);
        check(tag, "dec_valid", {31'd0, bus.dec_valid}, {31'd0, v.e_dv});
        check(tag, "dec_pc",    bus.dec_pc,             v.e_dv ? v.e_pc : 32'd0);
        check(tag, "dec_inst",  bus.dec_inst,           v.e_dv ? (v.e_pc ^ K) : 32'd0);
`ifdef IFU_PERF_EN
        if (v.chk_perf) begin
            check(tag, "perf_fetch_cnt", perf_fetch_cnt, v.e_fcnt);
            check(tag, "perf_stall_cnt", perf_stall_cnt, v.e_scnt);
        end
`endif
        a = bus.ic_addr;
        r = bus.ic_req;
        @(posedge clk);
        #1;
        if (r) bus.ic_data = a ^ K;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.ic_data        = '0;
        bus.ic_stall_n     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b1;

        // cycles 0-9: hits, miss at 0x10 stalling cycles 5-6
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h04, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h08, 1, 32'h00));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h0C, 1, 32'h04));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h10, 1, 32'h08));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 32'h0C));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h14, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h18, 1, 32'h10));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h1C, 1, 32'h14));
        // cycles 10-19: decode stalled, queue fills to 4 and ic_req drops
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h20, 1, 32'h18));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h24, 1, 32'h18));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h28, 1, 32'h18));
        for (int i = 13; i <= 19; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 32'h28, 1, 32'h18));
        // cycles 20-24: release, contiguous PCs
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h28, 1, 32'h18));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h28, 1, 32'h1C));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h2C, 1, 32'h20));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h30, 1, 32'h24));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h34, 1, 32'h28));
        // cycle 25: redirect (low bits set) with two queued and a completing hit
        vecs.push_back(mk(1, 1, 32'h201, 1, 1, 32'h38, 1, 32'h2C));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h200, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h204, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h208, 1, 32'h200));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h20C, 1, 32'h204));
        // cycle 30: redirect to 0x40; cycle 32: redirect to 0x300 during the 0x40 miss
        vecs.push_back(mk(1, 1, 32'h40, 1, 1, 32'h210, 1, 32'h208));
        vecs.push_back(perf(mk(1, 0, 0, 1, 1, 32'h40, 0, 0), 32'd16, 32'd2));
        vecs.push_back(mk(0, 1, 32'h300, 1, 1, 32'h40, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h40, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h300, 0, 0));
        vecs.push_back(perf(mk(1, 0, 0, 1, 1, 32'h304, 0, 0), 32'd16, 32'd4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h308, 1, 32'h300));
        vecs.push_back(perf(mk(1, 0, 0, 1, 1, 32'h30C, 1, 32'h304), 32'd18, 32'd4));

        // Reset state while rst_n is still low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", "ic_req",    {31'd0, bus.ic_req},    32'd0);
        check("reset", "ic_addr",   bus.ic_addr,            32'd0);
        check("reset", "dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        check("reset", "dec_pc",    bus.dec_pc,             32'd0);
        check("reset", "dec_inst",  bus.dec_inst,           32'd0);
`ifdef IFU_PERF_EN
        check("reset", "perf_fetch_cnt", perf_fetch_cnt, 32'd0);
        check("reset", "perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("c%0d", i));

        // One-cycle reset mid-stream with a request in flight
        rst_n = 1'b0;
        bus.ic_stall_n     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.dec_ready      = 1'b1;
        @(negedge clk);
        check("mid_rst", "ic_req", {31'd0, bus.ic_req}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(perf(mk(1, 0, 0, 1, 1, 32'h00, 0, 0), 32'd0, 32'd0), "rst_c0");
        step(mk(1, 0, 0, 1, 1, 32'h04, 0, 0), "rst_c1");
        step(mk(1, 0, 0, 1, 1, 32'h08, 1, 32'h00), "rst_c2");
        step(mk(1, 0, 0, 1, 1, 32'h0C, 1, 32'h04), "rst_c3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
